serial_logic_unit: RTL and testbench

Parametrised multi-cycle bitwise logic unit: accepts two WIDTH-bit operands and an opcode through a valid/ready handshake, evaluates the selected function SLICE bits per cycle (LSB slice first), then presents the registered result until consumed. It generalises the single-bit AND/OR/NOT gate set to eight functions, arbitrary width and a sequential datapath. Every per-slice function is built from NOR primitives only. It sits between operand registers and any downstream consumer that accepts a valid/ready result stream.

---
 rtl/serial_logic_unit_pkg.sv | 25 ++
 rtl/serial_logic_unit_nor_slice.sv | 52 +++++
 rtl/serial_logic_unit.sv | 153 +++++++++++++++
 tb/tb_serial_logic_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_logic_unit_pkg.sv
// Shared definitions for the serial logic unit: opcode encodings, FSM states
// and the slice-counter width helper.
package serial_logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NOTA  = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_NAND  = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single slice still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_logic_unit_nor_slice.sv
// Combinational SLICE-wide function unit; every function is composed purely of
// two-input NOR gates, then selected by the opcode.
module nor_slice #(
    parameter int SLICE = 2
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);
    import serial_logic_unit_pkg::*;

    logic [SLICE-1:0] na_s;
    logic [SLICE-1:0] nb_s;
    logic [SLICE-1:0] nor_s;
    logic [SLICE-1:0] or_s;
    logic [SLICE-1:0] and_s;
    logic [SLICE-1:0] nand_s;
    logic [SLICE-1:0] xor_s;
    logic [SLICE-1:0] xnor_s;
    logic [SLICE-1:0] pass_s;

    // XOR = nor(a&b, ~(a|b)); inverters are nor(x, 0).
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        nor u_na   (na_s[i],   a[i],     1'b0);
        nor u_nb   (nb_s[i],   b[i],     1'b0);
        nor u_nor  (nor_s[i],  a[i],     b[i]);
        nor u_or   (or_s[i],   nor_s[i], 1'b0);
        nor u_and  (and_s[i],  na_s[i],  nb_s[i]);
        nor u_nand (nand_s[i], and_s[i], 1'b0);
        nor u_xor  (xor_s[i],  and_s[i], nor_s[i]);
        nor u_xnor (xnor_s[i], xor_s[i], 1'b0);
        nor u_pass (pass_s[i], na_s[i],  1'b0);
    end

    // Opcode select of the precomputed NOR networks.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = and_s;
            OP_OR:    y = or_s;
            OP_NOTA:  y = na_s;
            OP_NOR:   y = nor_s;
            OP_NAND:  y = nand_s;
            OP_XOR:   y = xor_s;
            OP_XNOR:  y = xnor_s;
            OP_PASSA: y = pass_s;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic unit: valid/ready operand intake, SLICE bits of the
// result per cycle (LSB first), registered result held until consumed.
module serial_logic_unit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    import serial_logic_unit_pkg::*;

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("serial_logic_unit: WIDTH must be >= 1 and a multiple of SLICE");
    end

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_nxt_s;
    logic               zero_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SLICE-1:0]   a_slice_s;
    logic [SLICE-1:0]   b_slice_s;
    logic [SLICE-1:0]   y_s;
    logic               accept_s;
    logic               last_s;

    assign last_s = (cnt_r == LAST_CNT);
    assign result = result_r;
    assign zero   = zero_r;

    // Counter-selected operand slices feeding the single function unit.
    always_comb begin
        a_slice_s = '0;
        b_slice_s = '0;
        for (int i = 0; i < N; i++) begin
            a_slice_s = (cnt_r == CNT_W'(i)) ? a_r[i*SLICE +: SLICE] : a_slice_s;
            b_slice_s = (cnt_r == CNT_W'(i)) ? b_r[i*SLICE +: SLICE] : b_slice_s;
        end
    end

    nor_slice #(.SLICE(SLICE)) u_nor_slice (
        .op (op_r),
        .a  (a_slice_s),
        .b  (b_slice_s),
        .y  (y_s)
    );

    // Result with the current slice replaced by the function output.
    always_comb begin
        result_nxt_s = result_r;
        for (int i = 0; i < N; i++) begin
            result_nxt_s[i*SLICE +: SLICE] = (cnt_r == CNT_W'(i)) ? y_s : result_r[i*SLICE +: SLICE];
        end
    end

    // Next-state and handshake decode; handshake outputs depend on state only.
    always_comb begin
        state_nxt_s = state_r;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, slice-by-slice result build and zero flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= 3'd0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r     <= op;
                        a_r      <= inA;
                        b_r      <= inB;
                        result_r <= '0;
                        cnt_r    <= '0;
                    end
                end
                ST_BUSY: begin
                    result_r <= result_nxt_s;
                    if (last_s) begin
                        zero_r <= ~|result_nxt_s;
                        cnt_r  <= '0;
                    end else begin
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench: three configurations (8/2, 8/8, 12/3) driven in lockstep
// and compared against a plain bitwise reference model.
module tb_serial_logic_unit;
    import serial_logic_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [11:0] inA;
    logic [11:0] inB;

    logic        ir0, ov0, z0;
    logic [7:0]  r0;
    logic        ir1, ov1, z1;
    logic [7:0]  r1;
    logic        ir2, ov2, z2;
    logic [11:0] r2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_logic_unit #(.WIDTH(8), .SLICE(2)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .op(op),
        .inA(inA[7:0]), .inB(inB[7:0]), .out_valid(ov0), .out_ready(out_ready),
        .result(r0), .zero(z0)
    );

    serial_logic_unit #(.WIDTH(8), .SLICE(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .op(op),
        .inA(inA[7:0]), .inB(inB[7:0]), .out_valid(ov1), .out_ready(out_ready),
        .result(r1), .zero(z1)
    );

    serial_logic_unit #(.WIDTH(12), .SLICE(3)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .op(op),
        .inA(inA), .inB(inB), .out_valid(ov2), .out_ready(out_ready),
        .result(r2), .zero(z2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [2:0] o, input logic [11:0] a,
                                          input logic [11:0] b, input int w);
        logic [31:0] full;
        logic [31:0] mask;
        case (o)
            OP_AND:   full = {20'd0, a & b};
            OP_OR:    full = {20'd0, a | b};
            OP_NOTA:  full = {20'd0, ~a};
            OP_NOR:   full = {20'd0, ~(a | b)};
            OP_NAND:  full = {20'd0, ~(a & b)};
            OP_XOR:   full = {20'd0, a ^ b};
            OP_XNOR:  full = {20'd0, ~(a ^ b)};
            default:  full = {20'd0, a};
        endcase
        mask = (32'd1 << w) - 32'd1;
        return 12'(full & mask);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation with out_ready held high; checks value, zero, latency, one-cycle valid.
    task automatic run_op(input logic [2:0] o, input logic [11:0] a, input logic [11:0] b);
        logic [11:0] e8;
        logic [11:0] e12;
        int lat[3];
        int hits[3];
        e8  = model(o, a, b, 8);
        e12 = model(o, a, b, 12);
        in_valid  = 1'b1;
        op        = o;
        inA       = a;
        inB       = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        inA      = 12'($urandom);
        inB      = 12'($urandom);
        op       = 3'($urandom);
        lat  = '{-1, -1, -1};
        hits = '{0, 0, 0};
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (ov0) begin
                hits[0]++;
                if (lat[0] < 0) begin
                    lat[0] = n;
                    check("res_w8s2", {24'd0, r0}, {24'd0, e8[7:0]});
                    check("zero_w8s2", {31'd0, z0}, {31'd0, e8[7:0] == 8'h00});
                end
            end
            if (ov1) begin
                hits[1]++;
                if (lat[1] < 0) begin
                    lat[1] = n;
                    check("res_w8s8", {24'd0, r1}, {24'd0, e8[7:0]});
                    check("zero_w8s8", {31'd0, z1}, {31'd0, e8[7:0] == 8'h00});
                end
            end
            if (ov2) begin
                hits[2]++;
                if (lat[2] < 0) begin
                    lat[2] = n;
                    check("res_w12s3", {20'd0, r2}, {20'd0, e12});
                    check("zero_w12s3", {31'd0, z2}, {31'd0, e12 == 12'h000});
                end
            end
        end
        check("lat_w8s2", lat[0], 32'd4);
        check("lat_w8s8", lat[1], 32'd1);
        check("lat_w12s3", lat[2], 32'd4);
        check("vcycles_w8s2", hits[0], 32'd1);
        check("vcycles_w8s8", hits[1], 32'd1);
        check("vcycles_w12s3", hits[2], 32'd1);
    endtask

    initial begin
        int prev;
        int outs;
        int waited;
        logic [11:0] ta;
        logic [11:0] tb;
        logic [11:0] texp;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        inA       = 12'd0;
        inB       = 12'd0;
        #3;
        check("rst_in_ready", {31'd0, ir0}, 32'd1);
        check("rst_out_valid", {31'd0, ov0}, 32'd0);
        check("rst_result", {24'd0, r0}, 32'd0);
        check("rst_zero", {31'd0, z0}, 32'd0);
        check("rst_result_w12", {20'd0, r2}, 32'd0);
        #4;
        reset = 1'b0;

        run_op(OP_AND,  12'h0F0, 12'h03C);
        run_op(OP_XOR,  12'h0AA, 12'h0FF);
        run_op(OP_NOTA, 12'h00F, 12'h0FF);
        run_op(OP_AND,  12'h0AA, 12'h055);
        run_op(OP_NAND, 12'h0FF, 12'h00F);

        for (int k = 0; k < 16; k++) begin
            run_op(3'(k % 8), 12'($urandom), 12'($urandom));
        end

        // Backpressure in DONE with a competing offer on the input side.
        in_valid  = 1'b1;
        op        = OP_AND;
        inA       = 12'h0F0;
        inB       = 12'h03C;
        out_ready = 1'b0;
        tick();
        op  = OP_XOR;
        inA = 12'h0AA;
        inB = 12'h0FF;
        waited = 0;
        while (!ov0 && waited < 10) begin
            tick();
            waited++;
        end
        check("bp_reach_done", {31'd0, ov0}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_result", {24'd0, r0}, 32'h30);
            check("bp_zero", {31'd0, z0}, 32'd0);
            check("bp_in_ready", {31'd0, ir0}, 32'd0);
            check("bp_out_valid", {31'd0, ov0}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", {31'd0, ir0}, 32'd1);
        check("bp_release_valid", {31'd0, ov0}, 32'd0);
        run_op(OP_XOR, 12'h0AA, 12'h0FF);

        // Asynchronous reset in the middle of BUSY.
        in_valid  = 1'b1;
        op        = OP_XNOR;
        inA       = 12'($urandom);
        inB       = 12'($urandom);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_result", {24'd0, r0}, 32'd0);
        check("arst_out_valid", {31'd0, ov0}, 32'd0);
        check("arst_in_ready", {31'd0, ir0}, 32'd1);
        check("arst_zero", {31'd0, z0}, 32'd0);
        check("arst_result_w12", {20'd0, r2}, 32'd0);
        check("arst_in_ready_w12", {31'd0, ir2}, 32'd1);
        #2;
        reset = 1'b0;
        outs = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ov0 || ov1 || ov2) begin
                outs++;
            end
        end
        check("arst_no_output", outs, 32'd0);
        run_op(OP_OR, 12'h001, 12'h080);

        // Back-to-back throughput on the 12/3 instance.
        ta   = 12'($urandom);
        tb   = 12'($urandom);
        texp = model(OP_XOR, ta, tb, 12);
        in_valid  = 1'b1;
        op        = OP_XOR;
        inA       = ta;
        inB       = tb;
        out_ready = 1'b1;
        prev = -1;
        outs = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (ov2) begin
                outs++;
                check("tp_result", {20'd0, r2}, {20'd0, texp});
                if (prev >= 0) begin
                    check("tp_period", n - prev, 32'd6);
                end
                prev = n;
            end
        end
        check("tp_count", outs, 32'd5);
        in_valid = 1'b0;
        waited = 0;
        while (!(ir0 && ir1 && ir2) && waited < 10) begin
            tick();
            waited++;
        end
        check("drain_idle", {31'd0, ir0 && ir1 && ir2}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
